pckthandler_mc: RTL and testbench

Multi-virtual-channel, width-parametrised CSI-2 packet handler. Sits after the lane merger/ECC stage, which supplies `ph_stream` and `ph_select`, and before pixel unpacking.
- Decodes short packets: FS, FE, LS, LE.
- Tracks frame state independently per virtual channel (VC).
- Extracts long-packet payload, qualified with byte enables and start-of-line/end-of-line flags.
- Reports protocol errors as single-cycle pulses.

---
 rtl/csi_pkg.sv | 24 ++
 rtl/pckt_byte_tracker.sv | 53 +++++
 rtl/pckthandler_mc.sv | 198 +++++++++++++++++++
 tb/tb_pckthandler_mc.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csi_pkg.sv
// Shared CSI-2 header definitions for the packet handler: data types,
// header field positions and the handler state encoding.
package csi_pkg;

   localparam logic [5:0] DT_FS    = 6'h00;
   localparam logic [5:0] DT_FE    = 6'h01;
   localparam logic [5:0] DT_LS    = 6'h02;
   localparam logic [5:0] DT_LE    = 6'h03;
   localparam logic [5:0] DT_RAW10 = 6'h2B;

   localparam int HDR_WC_MSB = 23;
   localparam int HDR_WC_LSB = 8;
   localparam int HDR_VC_MSB = 7;
   localparam int HDR_VC_LSB = 6;
   localparam int HDR_DT_MSB = 5;
   localparam int HDR_DT_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/pckt_byte_tracker.sv
// Remaining-byte counter for one long packet; flags the first and last beat
// and produces the valid-byte mask of the current beat.
module pckt_byte_tracker #(
   parameter int BPC = 2
) (
   input  logic           rxbyteclkhs,
   input  logic           reset,
   input  logic           load,
   input  logic [15:0]    wc,
   input  logic           advance,
   output logic [BPC-1:0] byte_en,
   output logic           last,
   output logic           first
);

   logic [16:0] remaining_q, remaining_d;
   logic        first_q, first_d;

   assign last  = (remaining_q <= 17'(BPC));
   assign first = first_q;

   // Byte i is valid while more than i bytes remain; saturates to all ones
   // on every beat but the last.
   always_comb begin
      byte_en = '0;
      for (int i = 0; i < BPC; i++) begin
         byte_en[i] = (remaining_q > 17'(i));
      end
   end

   always_comb begin
      remaining_d = remaining_q;
      first_d     = first_q;
      if (load) begin
         remaining_d = {1'b0, wc};
         first_d     = 1'b1;
      end else if (advance) begin
         remaining_d = last ? 17'd0 : (remaining_q - 17'(BPC));
         first_d     = 1'b0;
      end
   end

   always_ff @(posedge rxbyteclkhs) begin
      if (reset) begin
         remaining_q <= '0;
         first_q     <= 1'b0;
      end else begin
         remaining_q <= remaining_d;
         first_q     <= first_d;
      end
   end

endmodule

// File: rtl/pckthandler_mc.sv
// Multi-VC CSI-2 packet handler: short-packet frame tracking and long-packet
// payload extraction. Optional per-VC filter: PCKTHANDLER_VC_FILTER_EN.
//
// state    | meaning
// ST_IDLE  | waiting for a packet header
// ST_RECV  | forwarding payload of an accepted pixel packet
// ST_DRAIN | discarding beats until end of transmission
module pckthandler_mc
   import csi_pkg::*;
#(
   parameter int         DATA_WIDTH = 16,
   parameter int         NUM_VC     = 4,
   parameter logic [5:0] PIXEL_DT   = DT_RAW10,
   localparam int        BPC        = DATA_WIDTH / 8
) (
   input  logic                  rxbyteclkhs,
   input  logic                  reset,
`ifdef PCKTHANDLER_VC_FILTER_EN
   input  logic [NUM_VC-1:0]     vc_enable,
`endif
   input  logic [DATA_WIDTH-1:0] data_stream,
   input  logic [23:0]           ph_stream,
   input  logic                  ph_select,
   input  logic                  valid_stream,
   input  logic                  ecc_error,
   output logic [DATA_WIDTH-1:0] out_stream,
   output logic [BPC-1:0]        out_byte_en,
   output logic                  out_valid,
   output logic                  out_sol,
   output logic                  out_eol,
   output logic [1:0]            out_vc,
   output logic [15:0]           line_count,
   output logic [NUM_VC-1:0]     frame_active,
   output logic                  err_no_frame,
   output logic                  err_truncated,
   output logic                  err_dup_fs
);

   state_t                state_q;
   logic [DATA_WIDTH-1:0] out_stream_q;
   logic [BPC-1:0]        out_byte_en_q;
   logic                  out_valid_q, out_sol_q, out_eol_q;
   logic [1:0]            vc_q;
   logic [3:0]            frame_active_q;
   logic [15:0]           line_cnt_q [4];
   logic                  err_no_frame_q, err_truncated_q, err_dup_fs_q;

   logic [15:0]           hdr_wc;
   logic [1:0]            hdr_vc;
   logic [5:0]            hdr_dt;
   logic                  hdr_fire;
   logic [3:0]            vc_en_w;
   logic                  vc_ok;
   logic                  trk_load, trk_advance;
   logic [BPC-1:0]        trk_byte_en;
   logic                  trk_last, trk_first;

   assign hdr_wc   = ph_stream[HDR_WC_MSB:HDR_WC_LSB];
   assign hdr_vc   = ph_stream[HDR_VC_MSB:HDR_VC_LSB];
   assign hdr_dt   = ph_stream[HDR_DT_MSB:HDR_DT_LSB];
   assign hdr_fire = valid_stream & ph_select & ~ecc_error;

   // VCs at or above NUM_VC read as disabled.
   always_comb begin
      vc_en_w = '0;
      for (int i = 0; i < NUM_VC; i++) begin
`ifdef PCKTHANDLER_VC_FILTER_EN
         vc_en_w[i] = vc_enable[i];
`else
         vc_en_w[i] = 1'b1;
`endif
      end
   end

   assign vc_ok = vc_en_w[hdr_vc];

   always_comb begin
      trk_load    = (state_q == ST_IDLE) && hdr_fire && vc_ok &&
                    (hdr_dt == PIXEL_DT) && frame_active_q[hdr_vc] &&
                    (hdr_wc != 16'd0);
      trk_advance = (state_q == ST_RECV) && valid_stream;
   end

   pckt_byte_tracker #(
      .BPC (BPC)
   ) u_byte_tracker (
      .rxbyteclkhs (rxbyteclkhs),
      .reset       (reset),
      .load        (trk_load),
      .wc          (hdr_wc),
      .advance     (trk_advance),
      .byte_en     (trk_byte_en),
      .last        (trk_last),
      .first       (trk_first)
   );

   always_ff @(posedge rxbyteclkhs) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         out_stream_q    <= '0;
         out_byte_en_q   <= '0;
         out_valid_q     <= 1'b0;
         out_sol_q       <= 1'b0;
         out_eol_q       <= 1'b0;
         vc_q            <= '0;
         frame_active_q  <= '0;
         err_no_frame_q  <= 1'b0;
         err_truncated_q <= 1'b0;
         err_dup_fs_q    <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            line_cnt_q[i] <= '0;
         end
      end else begin
         out_byte_en_q   <= '0;
         out_valid_q     <= 1'b0;
         out_sol_q       <= 1'b0;
         out_eol_q       <= 1'b0;
         err_no_frame_q  <= 1'b0;
         err_truncated_q <= 1'b0;
         err_dup_fs_q    <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (hdr_fire) begin
                  if (!vc_ok) begin
                     state_q <= ST_DRAIN;
                  end else if (hdr_dt == DT_FS) begin
                     if (frame_active_q[hdr_vc]) begin
                        err_dup_fs_q <= 1'b1;
                     end else begin
                        frame_active_q[hdr_vc] <= 1'b1;
                        line_cnt_q[hdr_vc]     <= '0;
                     end
                  end else if (hdr_dt == DT_FE) begin
                     frame_active_q[hdr_vc] <= 1'b0;
                  end else if ((hdr_dt == DT_LS) || (hdr_dt == DT_LE)) begin
                     state_q <= ST_IDLE;
                  end else if (hdr_dt == PIXEL_DT) begin
                     if (!frame_active_q[hdr_vc]) begin
                        err_no_frame_q <= 1'b1;
                        state_q        <= ST_DRAIN;
                     end else if (hdr_wc == 16'd0) begin
                        state_q <= ST_DRAIN;
                     end else begin
                        vc_q    <= hdr_vc;
                        state_q <= ST_RECV;
                     end
                  end else begin
                     state_q <= ST_DRAIN;
                  end
               end else if (valid_stream || ecc_error) begin
                  state_q <= ST_DRAIN;
               end
            end

            ST_RECV: begin
               if (valid_stream) begin
                  out_stream_q  <= data_stream;
                  out_valid_q   <= 1'b1;
                  out_sol_q     <= trk_first;
                  out_byte_en_q <= trk_byte_en;
                  if (trk_last) begin
                     out_eol_q <= 1'b1;
                     if (line_cnt_q[vc_q] != 16'hFFFF) begin
                        line_cnt_q[vc_q] <= line_cnt_q[vc_q] + 16'd1;
                     end
                     state_q <= ST_DRAIN;
                  end
               end else begin
                  err_truncated_q <= 1'b1;
                  state_q         <= ST_IDLE;
               end
            end

            ST_DRAIN: begin
               if (!valid_stream) begin
                  state_q <= ST_IDLE;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign out_stream    = out_stream_q;
   assign out_byte_en   = out_byte_en_q;
   assign out_valid     = out_valid_q;
   assign out_sol       = out_sol_q;
   assign out_eol       = out_eol_q;
   assign out_vc        = vc_q;
   assign line_count    = line_cnt_q[vc_q];
   assign frame_active  = frame_active_q[NUM_VC-1:0];
   assign err_no_frame  = err_no_frame_q;
   assign err_truncated = err_truncated_q;
   assign err_dup_fs    = err_dup_fs_q;

endmodule

// File: tb/tb_pckthandler_mc.sv
// Directed bench for pckthandler_mc: a 16-bit and a 32-bit instance share one
// header/payload stream; VC filter cases run when PCKTHANDLER_VC_FILTER_EN is set.
module tb_pckthandler_mc;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        valid_stream, ph_select, ecc_error;
   logic [23:0] ph_stream;
   logic [31:0] data32;
   logic [3:0]  vc_enable;

   logic [15:0] os16;
   logic [1:0]  be16;
   logic        ov16, sol16, eol16, enf16, etr16, edf16;
   logic [1:0]  vc16;
   logic [15:0] lc16;
   logic [3:0]  fa16;

   logic [31:0] os32;
   logic [3:0]  be32;
   logic        ov32, sol32, eol32, enf32, etr32, edf32;
   logic [1:0]  vc32;
   logic [15:0] lc32;
   logic [3:0]  fa32;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_sys = ~clk_sys;

   pckthandler_mc #(.DATA_WIDTH(16), .NUM_VC(4)) dut16 (
      .rxbyteclkhs   (clk_sys),
      .reset         (reset),
`ifdef PCKTHANDLER_VC_FILTER_EN
      .vc_enable     (vc_enable),
`endif
      .data_stream   (data32[15:0]),
      .ph_stream     (ph_stream),
      .ph_select     (ph_select),
      .valid_stream  (valid_stream),
      .ecc_error     (ecc_error),
      .out_stream    (os16),
      .out_byte_en   (be16),
      .out_valid     (ov16),
      .out_sol       (sol16),
      .out_eol       (eol16),
      .out_vc        (vc16),
      .line_count    (lc16),
      .frame_active  (fa16),
      .err_no_frame  (enf16),
      .err_truncated (etr16),
      .err_dup_fs    (edf16)
   );

   pckthandler_mc #(.DATA_WIDTH(32), .NUM_VC(4)) dut32 (
      .rxbyteclkhs   (clk_sys),
      .reset         (reset),
`ifdef PCKTHANDLER_VC_FILTER_EN
      .vc_enable     (vc_enable),
`endif
      .data_stream   (data32),
      .ph_stream     (ph_stream),
      .ph_select     (ph_select),
      .valid_stream  (valid_stream),
      .ecc_error     (ecc_error),
      .out_stream    (os32),
      .out_byte_en   (be32),
      .out_valid     (ov32),
      .out_sol       (sol32),
      .out_eol       (eol32),
      .out_vc        (vc32),
      .line_count    (lc32),
      .frame_active  (fa32),
      .err_no_frame  (enf32),
      .err_truncated (etr32),
      .err_dup_fs    (edf32)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic hdr(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
      valid_stream = 1'b1;
      ph_select    = 1'b1;
      ph_stream    = {wc, vc, dt};
      tick();
      ph_select    = 1'b0;
   endtask

   task automatic beat(input logic [31:0] d);
      valid_stream = 1'b1;
      ph_select    = 1'b0;
      data32       = d;
      tick();
   endtask

   task automatic eot;
      valid_stream = 1'b0;
      ph_select    = 1'b0;
      tick();
   endtask

   initial begin
      reset        = 1'b1;
      valid_stream = 1'b0;
      ph_select    = 1'b0;
      ecc_error    = 1'b0;
      ph_stream    = '0;
      data32       = '0;
      vc_enable    = 4'b1111;
      repeat (3) tick();
      reset = 1'b0;

      chk("rst_valid", 32'(ov16), 32'h0);
      chk("rst_fa", 32'(fa16), 32'h0);
      chk("rst_lc", 32'(lc16), 32'h0);
      chk("rst_be", 32'(be16), 32'h0);
      chk("rst_err", 32'({enf16, etr16, edf16}), 32'h0);

      // 1: FS, RAW10 WC=5 in three 16-bit beats, FE
      hdr(2'd0, 6'h00, 16'd0);
      chk("t1_fs_fa", 32'(fa16), 32'h1);
      eot();
      hdr(2'd0, 6'h2B, 16'd5);
      chk("t1_hdr_novalid", 32'(ov16), 32'h0);
      beat(32'h5555_A1B2);
      chk("t1_b1_valid", 32'(ov16), 32'h1);
      chk("t1_b1_be", 32'(be16), 32'h3);
      chk("t1_b1_sol", 32'(sol16), 32'h1);
      chk("t1_b1_eol", 32'(eol16), 32'h0);
      chk("t1_b1_data", 32'(os16), 32'hA1B2);
      chk("t1_b1_be32", 32'(be32), 32'hF);
      beat(32'h6666_C3D4);
      chk("t1_b2_be", 32'(be16), 32'h3);
      chk("t1_b2_sol", 32'(sol16), 32'h0);
      chk("t1_b2_eol", 32'(eol16), 32'h0);
      chk("t1_b2_data", 32'(os16), 32'hC3D4);
      chk("t1_b2_be32", 32'(be32), 32'h1);
      chk("t1_b2_eol32", 32'(eol32), 32'h1);
      chk("t1_b2_lc", 32'(lc16), 32'h0);
      beat(32'h7777_00E5);
      chk("t1_b3_be", 32'(be16), 32'h1);
      chk("t1_b3_eol", 32'(eol16), 32'h1);
      chk("t1_b3_lc", 32'(lc16), 32'h1);
      chk("t1_b3_vc", 32'(vc16), 32'h0);
      chk("t1_b3_valid32", 32'(ov32), 32'h0);
      eot();
      chk("t1_eot_valid", 32'(ov16), 32'h0);
      chk("t1_eot_be", 32'(be16), 32'h0);
      chk("t1_eot_hold", 32'(os16), 32'h00E5);
      hdr(2'd0, 6'h01, 16'd0);
      chk("t1_fe_fa", 32'(fa16), 32'h0);
      eot();

      // 2: pixel packet on VC2 without a frame
      hdr(2'd2, 6'h2B, 16'd4);
      chk("t2_nofr", 32'(enf16), 32'h1);
      chk("t2_valid_h", 32'(ov16), 32'h0);
      beat(32'h1234_5678);
      chk("t2_valid_b1", 32'(ov16), 32'h0);
      chk("t2_nofr_pulse", 32'(enf16), 32'h0);
      beat(32'h1234_5678);
      chk("t2_valid_b2", 32'(ov16), 32'h0);
      eot();

      // 3: truncated packet on VC1, then a header is decoded normally
      hdr(2'd1, 6'h00, 16'd0);
      eot();
      hdr(2'd1, 6'h2B, 16'd8);
      beat(32'h0000_1111);
      chk("t3_b1_sol", 32'(sol16), 32'h1);
      beat(32'h0000_2222);
      chk("t3_b2_be", 32'(be16), 32'h3);
      chk("t3_b2_trunc", 32'(etr16), 32'h0);
      eot();
      chk("t3_trunc", 32'(etr16), 32'h1);
      chk("t3_trunc_valid", 32'(ov16), 32'h0);
      chk("t3_trunc_eol", 32'(eol16), 32'h0);
      chk("t3_vc", 32'(vc16), 32'h1);
      chk("t3_lc", 32'(lc16), 32'h0);
      chk("t3_lc32", 32'(lc32), 32'h1);
      hdr(2'd2, 6'h00, 16'd0);
      chk("t3_next_fa", 32'(fa16), 32'h6);
      chk("t3_trunc_pulse", 32'(etr16), 32'h0);
      eot();

      // 4: duplicate FS on VC0, then FE
      hdr(2'd0, 6'h00, 16'd0);
      chk("t4_fs_fa", 32'(fa16), 32'h7);
      chk("t4_fs_nodup", 32'(edf16), 32'h0);
      eot();
      hdr(2'd0, 6'h00, 16'd0);
      chk("t4_dup", 32'(edf16), 32'h1);
      chk("t4_dup_fa", 32'(fa16), 32'h7);
      eot();
      chk("t4_dup_pulse", 32'(edf16), 32'h0);
      hdr(2'd0, 6'h01, 16'd0);
      chk("t4_fe_fa", 32'(fa16), 32'h6);
      eot();

      // 5: 32-bit single beat WC=3; ECC-flagged FS ignored
      hdr(2'd0, 6'h00, 16'd0);
      eot();
      hdr(2'd0, 6'h2B, 16'd3);
      beat(32'h00CC_BBAA);
      chk("t5_valid32", 32'(ov32), 32'h1);
      chk("t5_be32", 32'(be32), 32'h7);
      chk("t5_sol32", 32'(sol32), 32'h1);
      chk("t5_eol32", 32'(eol32), 32'h1);
      chk("t5_data32", os32, 32'h00CC_BBAA);
      chk("t5_lc32", 32'(lc32), 32'h1);
      eot();
      ecc_error = 1'b1;
      hdr(2'd3, 6'h00, 16'd0);
      chk("t5_ecc_fa16", 32'(fa16), 32'h7);
      chk("t5_ecc_fa32", 32'(fa32), 32'h7);
      ecc_error = 1'b0;
      eot();
      hdr(2'd1, 6'h01, 16'd0);
      chk("t5_fe1_fa", 32'(fa16), 32'h5);
      eot();

`ifdef PCKTHANDLER_VC_FILTER_EN
      // 6: VC1 and VC2 disabled
      vc_enable = 4'b0001;
      hdr(2'd1, 6'h00, 16'd0);
      chk("t6_fs_fa", 32'(fa16), 32'h5);
      chk("t6_fs_err", 32'({enf16, etr16, edf16}), 32'h0);
      eot();
      hdr(2'd1, 6'h2B, 16'd4);
      chk("t6_hdr_err", 32'({enf16, etr16, edf16}), 32'h0);
      beat(32'hDEAD_BEEF);
      chk("t6_b1_valid", 32'(ov16), 32'h0);
      beat(32'hDEAD_BEEF);
      chk("t6_b2_valid", 32'(ov16), 32'h0);
      chk("t6_b2_err", 32'({enf16, etr16, edf16}), 32'h0);
      eot();
      chk("t6_eot_err", 32'({enf16, etr16, edf16}), 32'h0);
      hdr(2'd2, 6'h01, 16'd0);
      chk("t6_fe_fa", 32'(fa16), 32'h5);
      eot();
      vc_enable = 4'b1111;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
